// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: shares one UART command/readback port between two requesters.
// Round-robin at transaction granularity; the grant is held from command issue
// until write-done, read-data return, or watchdog abort.
module uart_cmd_arbiter #(
   parameter int unsigned CMD_WIDTH  = 16,
   parameter int unsigned READ_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 50000,
   parameter int unsigned TO_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CMD_WIDTH-1:0]  s0_cmd,
   input  logic                  s0_vld,
   output logic                  s0_rdy,
   output logic [READ_WIDTH-1:0] s0_rsp_data,
   output logic                  s0_rsp_vld,
   output logic                  s0_rsp_err,
   input  logic [CMD_WIDTH-1:0]  s1_cmd,
   input  logic                  s1_vld,
   output logic                  s1_rdy,
   output logic [READ_WIDTH-1:0] s1_rsp_data,
   output logic                  s1_rsp_vld,
   output logic                  s1_rsp_err,
   output logic [CMD_WIDTH-1:0]  m_cmd,
   output logic                  m_cmd_vld,
   input  logic                  m_cmd_rdy,
   input  logic                  m_read_rdy,
   input  logic [READ_WIDTH-1:0] m_read_data,
   output logic                  busy,
   output logic                  owner
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ISSUE     = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_RESP      = 3'd4;

   localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT - 1);

   logic [2:0]            state_q, state_d;
   logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
   logic                  cmd_vld_q, cmd_vld_d;
   logic                  owner_q, owner_d;
   logic                  last_q, last_d;
   logic [TO_WIDTH-1:0]   wd_q, wd_d;
   logic [READ_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  s0_rsp_vld_q, s0_rsp_vld_d;
   logic                  s1_rsp_vld_q, s1_rsp_vld_d;
   logic                  busy_q, busy_d;

   logic                  grant_c;
   logic                  idle_c;
   logic                  is_wr_c;
   logic                  done_c;
   logic                  in_txn_c;

   // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      grant_c = s1_vld;
      if (s0_vld && s1_vld) begin
         grant_c = ~last_q;
      end
   end

   assign idle_c   = (state_q == ST_IDLE);
   assign s0_rdy   = idle_c & s0_vld & ~grant_c;
   assign s1_rdy   = idle_c & s1_vld & grant_c;
   assign is_wr_c  = cmd_q[CMD_WIDTH-1];
   assign in_txn_c = (state_q == ST_ISSUE) | (state_q == ST_WAIT_BUSY) | (state_q == ST_WAIT_DONE);

   // Completion: a write ends on cmd_rdy returning; a read ends on its data strobe.
   assign done_c = ((state_q == ST_WAIT_BUSY) & ~is_wr_c & m_read_rdy) |
                   ((state_q == ST_WAIT_DONE) & (is_wr_c ? m_cmd_rdy : m_read_rdy));

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cmd_vld_d    = cmd_vld_q;
      owner_d      = owner_q;
      last_d       = last_q;
      wd_d         = wd_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      s0_rsp_vld_d = 1'b0;
      s1_rsp_vld_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s0_vld || s1_vld) begin
               state_d   = ST_ISSUE;
               cmd_d     = grant_c ? s1_cmd : s0_cmd;
               cmd_vld_d = 1'b1;
               owner_d   = grant_c;
               last_d    = grant_c;
               wd_d      = '0;
            end
         end
         ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE: begin
            wd_d = wd_q + TO_WIDTH'(1);
            if (done_c) begin
               state_d      = ST_RESP;
               cmd_vld_d    = 1'b0;
               rsp_data_d   = is_wr_c ? '0 : m_read_data;
               rsp_err_d    = 1'b0;
               s0_rsp_vld_d = ~owner_q;
               s1_rsp_vld_d = owner_q;
            end else if (wd_q == WD_LAST) begin
               state_d      = ST_RESP;
               cmd_vld_d    = 1'b0;
               rsp_data_d   = '0;
               rsp_err_d    = 1'b1;
               s0_rsp_vld_d = ~owner_q;
               s1_rsp_vld_d = owner_q;
            end else if ((state_q == ST_ISSUE) && m_cmd_rdy) begin
               state_d   = ST_WAIT_BUSY;
               cmd_vld_d = 1'b0;
            end else if ((state_q == ST_WAIT_BUSY) && !m_cmd_rdy) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            cmd_vld_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset drops any in-flight command without a response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cmd_q        <= '0;
         cmd_vld_q    <= 1'b0;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         wd_q         <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         s0_rsp_vld_q <= 1'b0;
         s1_rsp_vld_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         cmd_vld_q    <= cmd_vld_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         wd_q         <= wd_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         s0_rsp_vld_q <= s0_rsp_vld_d;
         s1_rsp_vld_q <= s1_rsp_vld_d;
         busy_q       <= busy_d;
      end
   end

   assign m_cmd       = cmd_q;
   assign m_cmd_vld   = cmd_vld_q;
   assign s0_rsp_data = rsp_data_q;
   assign s1_rsp_data = rsp_data_q;
   assign s0_rsp_err  = rsp_err_q;
   assign s1_rsp_err  = rsp_err_q;
   assign s0_rsp_vld  = s0_rsp_vld_q;
   assign s1_rsp_vld  = s1_rsp_vld_q;
   assign busy        = busy_q;
   assign owner       = owner_q;

   // in_txn_c documents the watchdog-counting window; keep it observable for debug.
   logic unused_c;
   assign unused_c = in_txn_c;

endmodule
